// File: rtl/req_ack_pkg.sv
// Shared types and constants for the request/acknowledge protocol checker.
package req_ack_pkg;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_MULTI   = 3'd1,
    ERR_UNEXP   = 3'd2,
    ERR_DATA    = 3'd3,
    ERR_OVF     = 3'd4,
    ERR_TIMEOUT = 3'd5
  } err_code_t;

  localparam logic [15:0] ERR_COUNT_MAX = 16'hFFFF;
  localparam logic [2:0]  RANK_NONE     = 3'd7;

  // Lower rank wins when several errors are found on the same edge.
  function automatic logic [2:0] err_rank(input err_code_t code);
    case (code)
      ERR_MULTI:   err_rank = 3'd0;
      ERR_UNEXP:   err_rank = 3'd1;
      ERR_DATA:    err_rank = 3'd2;
      ERR_OVF:     err_rank = 3'd3;
      ERR_TIMEOUT: err_rank = 3'd4;
      default:     err_rank = RANK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/req_ack_chan.sv
// One monitored channel: in-order FIFO of outstanding request data, occupancy
// count, head age and one-shot timeout flag. Error flags are combinational.
module req_ack_chan
  import req_ack_pkg::*;
#(
  parameter int DW      = 32,
  parameter int MAXOUT  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req,
  input  logic [DW-1:0] i_req_data,
  input  logic          i_ack,
  input  logic [DW-1:0] i_ack_data,
  output logic          o_unexp,
  output logic          o_data_err,
  output logic          o_ovf,
  output logic          o_timeout,
  output logic          o_nonempty_nxt
);

  localparam int CW = $clog2(MAXOUT + 1);
  localparam int PW = (MAXOUT > 1) ? $clog2(MAXOUT) : 1;
  localparam int AW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] CNT_FULL = CW'(MAXOUT);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAXOUT - 1);
  localparam logic [AW-1:0] AGE_MAX  = AW'(TIMEOUT);
  localparam logic [AW-1:0] AGE_TRIP = AW'(TIMEOUT - 1);

  logic [DW-1:0] r_mem [MAXOUT];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_age;
  logic          r_to_flag;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_cmp_en;
  logic [DW-1:0] w_cmp_data;
  logic [CW-1:0] w_cnt_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CNT_FULL);

  always_comb begin
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_cmp_en   = 1'b0;
    w_cmp_data = i_req_data;
    o_unexp    = 1'b0;
    o_ovf      = 1'b0;
    if (i_req && i_ack) begin
      w_cmp_en = 1'b1;
      if (!w_empty) begin
        // Pop and push together keep the count, so this is legal even when full.
        w_cmp_data = r_mem[r_rd_ptr];
        w_pop      = 1'b1;
        w_push     = 1'b1;
      end
    end else if (i_ack) begin
      if (w_empty) begin
        o_unexp = 1'b1;
      end else begin
        w_cmp_en   = 1'b1;
        w_cmp_data = r_mem[r_rd_ptr];
        w_pop      = 1'b1;
      end
    end else if (i_req) begin
      if (w_full) o_ovf  = 1'b1;
      else        w_push = 1'b1;
    end
  end

  assign o_data_err = w_cmp_en && (w_cmp_data != i_ack_data);
  assign o_timeout  = !w_empty && (r_age == AGE_TRIP) && !r_to_flag;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)      w_cnt_nxt = r_cnt + 1'b1;
    else if (w_pop && !w_push) w_cnt_nxt = r_cnt - 1'b1;
  end

  assign o_nonempty_nxt = (w_cnt_nxt != '0);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_req_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      r_age     <= '0;
      r_to_flag <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      // A new head restarts its age; otherwise the head keeps ageing.
      if (w_pop || (w_empty && w_push)) begin
        r_age     <= '0;
        r_to_flag <= 1'b0;
      end else if (!w_empty) begin
        if (r_age != AGE_MAX) r_age <= r_age + 1'b1;
        if (o_timeout)        r_to_flag <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_ack_checker.sv
// Multi-channel request/acknowledge protocol checker: per-channel tracking plus
// multi-ack detection, single prioritised error report, error counter and busy.
module req_ack_checker
  import req_ack_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DW      = 32,
  parameter int MAXOUT  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*DW-1:0] req_data,
  input  logic [NCH-1:0]    ack,
  input  logic [DW-1:0]     ack_data,
  output logic              err_valid,
  output logic [2:0]        err_code,
  output logic [3:0]        err_chan,
  output logic [15:0]       err_count,
  output logic              busy
);

  logic [NCH-1:0] w_unexp;
  logic [NCH-1:0] w_data_err;
  logic [NCH-1:0] w_ovf;
  logic [NCH-1:0] w_timeout;
  logic [NCH-1:0] w_nonempty_nxt;
  logic           w_multi;
  err_code_t      w_code;
  logic [3:0]     w_chan;
  logic [2:0]     w_rank;

  logic           r_err_valid;
  err_code_t      r_err_code;
  logic [3:0]     r_err_chan;
  logic [15:0]    r_err_count;
  logic           r_busy;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    req_ack_chan #(
      .DW      (DW),
      .MAXOUT  (MAXOUT),
      .TIMEOUT (TIMEOUT)
    ) u_chan (
      .i_clk          (clk),
      .i_rst          (reset),
      .i_req          (req[g]),
      .i_req_data     (req_data[g*DW +: DW]),
      .i_ack          (ack[g]),
      .i_ack_data     (ack_data),
      .o_unexp        (w_unexp[g]),
      .o_data_err     (w_data_err[g]),
      .o_ovf          (w_ovf[g]),
      .o_timeout      (w_timeout[g]),
      .o_nonempty_nxt (w_nonempty_nxt[g])
    );
  end

  // Clearing the lowest set bit leaves something only if two or more are set.
  assign w_multi = ((ack & (ack - 1'b1)) != '0);

  // Descending scan with <= lets the lowest channel win among equal ranks.
  always_comb begin
    w_code = ERR_NONE;
    w_chan = '0;
    w_rank = RANK_NONE;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (w_timeout[c] && (err_rank(ERR_TIMEOUT) <= w_rank)) begin
        w_code = ERR_TIMEOUT;
        w_rank = err_rank(ERR_TIMEOUT);
        w_chan = 4'(c);
      end
      if (w_ovf[c] && (err_rank(ERR_OVF) <= w_rank)) begin
        w_code = ERR_OVF;
        w_rank = err_rank(ERR_OVF);
        w_chan = 4'(c);
      end
      if (w_data_err[c] && (err_rank(ERR_DATA) <= w_rank)) begin
        w_code = ERR_DATA;
        w_rank = err_rank(ERR_DATA);
        w_chan = 4'(c);
      end
      if (w_unexp[c] && (err_rank(ERR_UNEXP) <= w_rank)) begin
        w_code = ERR_UNEXP;
        w_rank = err_rank(ERR_UNEXP);
        w_chan = 4'(c);
      end
      if (w_multi && ack[c] && (err_rank(ERR_MULTI) <= w_rank)) begin
        w_code = ERR_MULTI;
        w_rank = err_rank(ERR_MULTI);
        w_chan = 4'(c);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_valid <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_err_chan  <= '0;
      r_err_count <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_err_valid <= (w_code != ERR_NONE);
      r_busy      <= |w_nonempty_nxt;
      if (w_code != ERR_NONE) begin
        r_err_code <= w_code;
        r_err_chan <= w_chan;
        if (r_err_count != ERR_COUNT_MAX) r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign err_valid = r_err_valid;
  assign err_code  = r_err_code;
  assign err_chan  = r_err_chan;
  assign err_count = r_err_count;
  assign busy      = r_busy;

endmodule

// File: tb/tb_req_ack_checker.sv
// Self-checking bench for req_ack_checker: directed scenarios plus random traffic,
// predicted by a queue-based reference model and checked through a scoreboard.
module tb_req_ack_checker;

  localparam int NCH     = 4;
  localparam int DW      = 32;
  localparam int MAXOUT  = 4;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    req;
  logic [NCH*DW-1:0] req_data;
  logic [NCH-1:0]    ack;
  logic [DW-1:0]     ack_data;
  logic              err_valid;
  logic [2:0]        err_code;
  logic [3:0]        err_chan;
  logic [15:0]       err_count;
  logic              busy;

  always #5 clk = ~clk;

  req_ack_checker #(
    .NCH (NCH), .DW (DW), .MAXOUT (MAXOUT), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .ack_data  (ack_data),
    .err_valid (err_valid),
    .err_code  (err_code),
    .err_chan  (err_chan),
    .err_count (err_count),
    .busy      (busy)
  );

  typedef struct {
    logic        v;
    logic [2:0]  code;
    logic [3:0]  chan;
    logic [15:0] cnt;
    logic        bsy;
  } exp_t;

  exp_t          sb [$];
  logic [DW-1:0] mq [NCH][$];
  int            head_at [NCH];
  int            edge_n;
  logic [2:0]    m_code;
  logic [3:0]    m_chan;
  logic [15:0]   m_cnt;
  int            n_cmp = 0;
  int            n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      head_at[c] = 0;
    end
    m_code = 3'd0;
    m_chan = 4'd0;
    m_cnt  = 16'd0;
    edge_n = 0;
  endtask

  // One clock edge of the reference: flags per code (2..5) per channel, then a
  // plain priority pick: multi first, then codes in order, lowest channel first.
  task automatic model_edge(input logic [NCH-1:0] rq, input logic [NCH*DW-1:0] rdf,
                            input logic [NCH-1:0] ak, input logic [DW-1:0] ad);
    bit            flg [6][NCH];
    bit            found;
    bit            bsy;
    int            n;
    logic [2:0]    code;
    logic [3:0]    chan;
    logic [DW-1:0] rd;
    logic [DW-1:0] h;
    for (int k = 0; k < 6; k++)
      for (int c = 0; c < NCH; c++) flg[k][c] = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      n  = mq[c].size();
      rd = rdf[c*DW +: DW];
      if (n > 0 && (edge_n - head_at[c]) == TIMEOUT) flg[5][c] = 1'b1;
      if (rq[c] && ak[c]) begin
        if (n == 0) begin
          if (rd != ad) flg[3][c] = 1'b1;
        end else begin
          h = mq[c].pop_front();
          if (h != ad) flg[3][c] = 1'b1;
          mq[c].push_back(rd);
          head_at[c] = edge_n;
        end
      end else if (ak[c]) begin
        if (n == 0) flg[2][c] = 1'b1;
        else begin
          h = mq[c].pop_front();
          if (h != ad) flg[3][c] = 1'b1;
          head_at[c] = edge_n;
        end
      end else if (rq[c]) begin
        if (n == MAXOUT) flg[4][c] = 1'b1;
        else begin
          mq[c].push_back(rd);
          if (n == 0) head_at[c] = edge_n;
        end
      end
    end
    found = 1'b0;
    code  = 3'd0;
    chan  = 4'd0;
    if ($countones(ak) > 1) begin
      found = 1'b1;
      code  = 3'd1;
      for (int c = NCH - 1; c >= 0; c--) if (ak[c]) chan = 4'(c);
    end
    for (int k = 2; k <= 5; k++)
      for (int c = 0; c < NCH; c++)
        if (!found && flg[k][c]) begin
          found = 1'b1;
          code  = 3'(k);
          chan  = 4'(c);
        end
    if (found) begin
      m_code = code;
      m_chan = chan;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    bsy = 1'b0;
    for (int c = 0; c < NCH; c++) if (mq[c].size() > 0) bsy = 1'b1;
    sb.push_back('{found, m_code, m_chan, m_cnt, bsy});
    edge_n++;
  endtask

  task automatic step(input logic [NCH-1:0] rq, input logic [NCH*DW-1:0] rdf,
                      input logic [NCH-1:0] ak, input logic [DW-1:0] ad);
    @(negedge clk);
    req      = rq;
    req_data = rdf;
    ack      = ak;
    ack_data = ad;
    model_edge(rq, rdf, ak, ad);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, '0);
  endtask

  function automatic logic [NCH*DW-1:0] one_data(input int c, input logic [DW-1:0] d);
    logic [NCH*DW-1:0] r;
    r = '0;
    r[c*DW +: DW] = d;
    return r;
  endfunction

  task automatic rand_cycle(input int preq, input int pack);
    logic [NCH-1:0]    rq;
    logic [NCH-1:0]    ak;
    logic [NCH*DW-1:0] rdf;
    logic [DW-1:0]     ad;
    for (int c = 0; c < NCH; c++) begin
      rq[c] = ($urandom_range(0, 99) < preq);
      ak[c] = ($urandom_range(0, 99) < pack);
      rdf[c*DW +: DW] = DW'($urandom_range(0, 3));
    end
    ad = DW'($urandom_range(0, 3));
    // Usually return the data the lowest acking channel is waiting for.
    for (int c = NCH - 1; c >= 0; c--)
      if (ak[c]) begin
        if (mq[c].size() > 0 && $urandom_range(0, 9) < 8) ad = mq[c][0];
        else if (rq[c]) ad = rdf[c*DW +: DW];
      end
    step(rq, rdf, ak, ad);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("err_valid", int'(err_valid), int'(e.v));
        chk("err_code",  int'(err_code),  int'(e.code));
        chk("err_chan",  int'(err_chan),  int'(e.chan));
        chk("err_count", int'(err_count), int'(e.cnt));
        chk("busy",      int'(busy),      int'(e.bsy));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int ack_vals [4];
    reset    = 1'b1;
    req      = '0;
    ack      = '0;
    req_data = '0;
    ack_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_err_valid", int'(err_valid), 0);
    chk("rst_err_code",  int'(err_code),  0);
    chk("rst_err_chan",  int'(err_chan),  0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_busy",      int'(busy),      0);

    // Clean round trip on ch0.
    step(4'b0001, one_data(0, 32'hfeed), '0, '0);
    idle(1);
    step('0, '0, 4'b0001, 32'hfeed);
    idle(1);

    // Unexpected ack on ch1.
    step('0, '0, 4'b0010, 32'h5);
    idle(1);

    // Fill ch2, overflow it, then drain with one bad data value.
    for (int i = 1; i <= 5; i++) step(4'b0100, one_data(2, DW'(i)), '0, '0);
    ack_vals = '{1, 2, 9, 4};
    for (int i = 0; i < 4; i++) step('0, '0, 4'b0100, DW'(ack_vals[i]));
    idle(1);

    // Timeout on ch3, reported once, then a late ack is accepted.
    step(4'b1000, one_data(3, 32'h33), '0, '0);
    idle(40);
    step('0, '0, 4'b1000, 32'h33);
    idle(1);

    // Two acks on one edge.
    step('0, '0, 4'b0110, 32'h0);
    idle(1);

    // Asynchronous reset with traffic outstanding on ch0.
    for (int i = 0; i < 3; i++) step(4'b0001, one_data(0, DW'(i + 10)), '0, '0);
    #2;
    reset = 1'b1;
    req   = '0;
    ack   = '0;
    sb.delete();
    model_reset();
    #1;
    chk("arst_err_valid", int'(err_valid), 0);
    chk("arst_err_code",  int'(err_code),  0);
    chk("arst_err_chan",  int'(err_chan),  0);
    chk("arst_err_count", int'(err_count), 0);
    chk("arst_busy",      int'(busy),      0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    step('0, '0, 4'b0001, 32'h7);
    idle(1);

    // Random traffic in several load mixes, including sparse acks for timeouts.
    for (int i = 0; i < 800; i++) rand_cycle(30, 25);
    for (int i = 0; i < 800; i++) rand_cycle(50, 10);
    for (int i = 0; i < 800; i++) rand_cycle(10, 3);
    for (int i = 0; i < 800; i++) rand_cycle(20, 20);
    idle(2);

    for (int i = 0; i < 4 && sb.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (sb.size() > 0) chk("scoreboard_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/req_ack_checker.md
Name: req_ack_checker

Overview:
- Synthesisable, parametrised successor to the simulation-only single-channel request/acknowledge assertion.
- Monitors NCH independent request/acknowledge channels that share one acknowledge data return bus.
- Per channel, queues outstanding request data in order and checks each acknowledge against the oldest entry; also checks ordering, overflow, timeout and that acks are at-most-one-hot.
- Sits beside the bus it observes; drives no functional logic, only error reporting.

Parameters:
- NCH, 4: number of channels (1..16).
- DW, 32: data width of req_data per channel and of ack_data.
- MAXOUT, 4: max outstanding requests per channel (power of 2, >=1).
- TIMEOUT, 16: cycles an oldest entry may wait before a timeout error (>=2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req  in  NCH  per-channel single-cycle request pulse.
- req_data  in  NCH*DW  request data; channel c at [c*DW +: DW].
- ack  in  NCH  per-channel single-cycle acknowledge pulse.
- ack_data  in  DW  shared acknowledge data; valid when any ack bit is set.
- err_valid  out  1  one-cycle error report pulse.
- err_code  out  3  error code (package enum).
- err_chan  out  4  channel of the reported error.
- err_count  out  16  saturating count of err_valid pulses.
- busy  out  1  any channel has count>0.

Behaviour:
- Reset values: all outputs 0, all counts 0, FIFOs empty, timeout flags clear. Reset asserted mid-operation discards everything and reports no error.
- Per channel c, state is evaluated from pre-edge values:
  - count c (0..MAXOUT).
  - FIFO of req_data, depth MAXOUT, with wrapping read and write pointers.
  - age counter, width $clog2(TIMEOUT+1).
  - to_flag.
- Per-channel channel events, each edge, first matching rule wins:
  - req & ack & count==0: pass-through. Compare ack_data to req_data[c]; a mismatch gives ERR_DATA. count stays 0.
  - req & ack & count>0: pop head and compare to ack_data (mismatch gives ERR_DATA), push req_data. count unchanged; allowed even at MAXOUT.
  - ack only, count==0: ERR_UNEXP; no state change.
  - ack only, count>0: pop and compare (ERR_DATA on mismatch); count-1.
  - req only, count==MAXOUT: ERR_OVF; request dropped.
  - req only, count<MAXOUT: push; count+1.
- Age and timeout:
  - When a pop occurs or the channel goes empty to non-empty: age resets to 0 and to_flag clears.
  - Otherwise, while count>0, age increments and saturates at TIMEOUT.
  - When age reaches TIMEOUT-1 with to_flag clear: raise ERR_TIMEOUT once and set to_flag. No repeat until the head changes.
  - Net effect: head outstanding TIMEOUT cycles gives the error.
- Multi-ack: popcount(ack)>1 gives ERR_MULTI, with err_chan = lowest set ack index. All channels still process their events normally, each comparing against the same ack_data.
- Reporting:
  - All errors found on an edge are registered and presented on the next cycle: latency 1.
  - Only one error is reported per cycle. Priority is MULTI > UNEXP > DATA > OVF > TIMEOUT; within a code, the lowest channel wins. Lower-priority errors in that cycle are dropped, not queued.
  - err_code and err_chan hold their last values when err_valid=0.
- err_count increments on every err_valid and saturates at 16'hFFFF.
- busy is registered and reflects post-edge counts.

Decomposition:
- Package req_ack_pkg holds:
  - 3-bit enum err_code_t: ERR_NONE=0, ERR_MULTI=1, ERR_UNEXP=2, ERR_DATA=3, ERR_OVF=4, ERR_TIMEOUT=5.
  - Priority ordering function.
  - Saturation constant for err_count.
- Sub-module req_ack_chan: one channel's FIFO, count, age and to_flag. Outputs per-channel unexp/data/ovf/timeout flags plus nonempty; instantiated NCH times by generate.
- Top level performs the multi-ack check, priority encode, err_count and busy.

Test Plan:
- Ch0 req, data 32'hfeed; ack 2 cycles later with ack_data 32'hfeed -> err_valid never asserts; busy 1 for 2 cycles then 0.
- Ch1 ack with no prior req -> err_valid=1 one cycle after, code 2, chan 1, err_count=1.
- Ch2 four reqs (data 1,2,3,4) then a 5th req -> ERR_OVF chan 2. Acks with 1,2,9,4 -> ERR_DATA on the 3rd ack only; count returns to 0.
- Ch3 req, no ack for 16 cycles -> single ERR_TIMEOUT chan 3 at cycle 16+1, no repeat at cycle 40. A subsequent ack clears to_flag without error.
- Same edge: ack=4'b0110 with ch1 and ch2 empty -> only ERR_MULTI chan 1 reported; err_count +1.
- Reset asserted with 3 outstanding on ch0 -> outputs 0 immediately (asynchronous). After release, a ch0 ack gives ERR_UNEXP.
